// File: rtl/mips_hazard_fwd_unit_pkg.sv
// Shared encodings for the MIPS hazard/forwarding slice: operand-select codes,
// freeze FSM states and the per-channel register-field slicing helper.
package mips_pkg;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    localparam int unsigned REG_AW_DEFAULT = 5;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } frzState_t;

    // LSB of operand channel ch inside a packed NUM_SRC*aw source bus
    function automatic int unsigned chanLsb(input int unsigned ch, input int unsigned aw);
        return ch * aw;
    endfunction

endpackage

// File: rtl/mips_hazard_fwd_unit_fwd_sel.sv
// Per-channel MEM/WB forwarding comparator; MEM has priority, r0 never forwards,
// and a captured operand always reads the local register.
module mips_fwd_sel
    import mips_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEFAULT
) (
    input  logic              regWriteMem,
    input  logic              regWriteWb,
    input  logic [REG_AW-1:0] writeRegMem,
    input  logic [REG_AW-1:0] writeRegWb,
    input  logic [REG_AW-1:0] srcReg,
    input  logic              captured,
    output logic [1:0]        sel
);

    logic memHit;
    logic wbHit;

    always_comb begin
        memHit = regWriteMem && (writeRegMem != '0) && (writeRegMem == srcReg);
        wbHit  = regWriteWb  && (writeRegWb  != '0) && (writeRegWb  == srcReg);
        sel    = FWD_NONE;
        if (captured) begin
            sel = FWD_NONE;
        end else if (memHit) begin
            sel = FWD_MEM;
        end else if (wbHit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/mips_hazard_fwd_unit.sv
// Hazard and forwarding unit: per-channel operand forwarding, load-use bubbles,
// multi-cycle load freeze with WB operand capture, and a saturating stall counter.
module mips_hazard_fwd_unit
    import mips_pkg::*;
#(
    parameter int unsigned REG_AW   = REG_AW_DEFAULT,
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      RegWriteMEM,
    input  logic                      RegWriteWB,
    input  logic [REG_AW-1:0]         WriteRegMEM,
    input  logic [REG_AW-1:0]         WriteRegWB,
    input  logic                      MemReadMEM,
    input  logic                      MemReadEX,
    input  logic [REG_AW-1:0]         WriteRegEX,
    input  logic [NUM_SRC*REG_AW-1:0] src_ex,
    input  logic [NUM_SRC*REG_AW-1:0] src_id,
    input  logic [NUM_SRC-1:0]        src_id_used,
    output logic [2*NUM_SRC-1:0]      fwd_sel,
    output logic [NUM_SRC-1:0]        ex_capture,
    output logic                      stall_if,
    output logic                      stall_id,
    output logic                      flush_ex,
    output logic                      freeze,
    output logic [CNT_W-1:0]          stall_cnt
);

    localparam logic [3:0] LAST_WCNT = 4'(LOAD_LAT - 1);

    frzState_t          state;
    frzState_t          nextState;
    logic [3:0]         wcnt;
    logic [3:0]         nextWcnt;
    logic               frzRaw;
    logic               srcMatch;
    logic               loadUse;
    logic [NUM_SRC-1:0] captured;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_chan
        mips_fwd_sel #(
            .REG_AW(REG_AW)
        ) u_sel (
            .regWriteMem(RegWriteMEM),
            .regWriteWb (RegWriteWB),
            .writeRegMem(WriteRegMEM),
            .writeRegWb (WriteRegWB),
            .srcReg     (src_ex[chanLsb(i, REG_AW) +: REG_AW]),
            .captured   (captured[i]),
            .sel        (fwd_sel[2*i +: 2])
        );
    end

    always_comb begin
        srcMatch = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (src_id_used[i] && (src_id[chanLsb(i, REG_AW) +: REG_AW] == WriteRegEX)) begin
                srcMatch = 1'b1;
            end
        end
        loadUse = MemReadEX && (WriteRegEX != '0) && srcMatch && !reset;
    end

    always_comb begin
        nextState = state;
        nextWcnt  = wcnt;
        frzRaw    = 1'b0;
        case (state)
            RUN: begin
                if (MemReadMEM && (LOAD_LAT > 1)) begin
                    frzRaw    = 1'b1;
                    nextWcnt  = 4'd1;
                    nextState = WAIT;
                end
            end
            WAIT: begin
                if (wcnt == LAST_WCNT) begin
                    nextWcnt  = '0;
                    nextState = RUN;
                end else begin
                    frzRaw   = 1'b1;
                    nextWcnt = wcnt + 4'd1;
                end
            end
            default: nextState = RUN;
        endcase
    end

    // Reset gates the combinational outputs so a mid-freeze reset releases at once
    always_comb begin
        freeze   = frzRaw && !reset;
        stall_if = freeze || loadUse;
        stall_id = freeze || loadUse;
        flush_ex = loadUse && !freeze;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            ex_capture[i] = freeze && (state == RUN) && (fwd_sel[2*i +: 2] == FWD_WB);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            wcnt      <= '0;
            captured  <= '0;
            stall_cnt <= '0;
        end else begin
            state    <= nextState;
            wcnt     <= nextWcnt;
            captured <= freeze ? (captured | ex_capture) : '0;
            if (stall_id && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mips_hazard_fwd_unit.sv
// Self-checking bench for mips_hazard_fwd_unit: directed vector table, hand-written
// freeze/capture/reset sequences, and randomized traffic against a behavioural model.
module tb_mips_hazard_fwd_unit;

    localparam int unsigned LAT = 3;
    localparam int unsigned CW  = 4;
    localparam int unsigned CNT_MAX = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteMEM, RegWriteWB, MemReadMEM, MemReadEX;
    logic [4:0]  WriteRegMEM, WriteRegWB, WriteRegEX;
    logic [9:0]  src_ex, src_id;
    logic [1:0]  src_id_used;

    logic [3:0]    fwd_sel, fwd_sel1;
    logic [1:0]    ex_capture, ex_capture1;
    logic          stall_if, stall_id, flush_ex, freeze;
    logic          stall_if1, stall_id1, flush_ex1, freeze1;
    logic [CW-1:0] stall_cnt;
    logic [15:0]   stall_cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_hazard_fwd_unit #(
        .REG_AW(5), .NUM_SRC(2), .LOAD_LAT(LAT), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .RegWriteMEM(RegWriteMEM), .RegWriteWB(RegWriteWB),
        .WriteRegMEM(WriteRegMEM), .WriteRegWB(WriteRegWB),
        .MemReadMEM(MemReadMEM), .MemReadEX(MemReadEX), .WriteRegEX(WriteRegEX),
        .src_ex(src_ex), .src_id(src_id), .src_id_used(src_id_used),
        .fwd_sel(fwd_sel), .ex_capture(ex_capture),
        .stall_if(stall_if), .stall_id(stall_id), .flush_ex(flush_ex),
        .freeze(freeze), .stall_cnt(stall_cnt)
    );

    mips_hazard_fwd_unit #(
        .REG_AW(5), .NUM_SRC(2), .LOAD_LAT(1), .CNT_W(16)
    ) dut1 (
        .clk(clk), .reset(reset),
        .RegWriteMEM(RegWriteMEM), .RegWriteWB(RegWriteWB),
        .WriteRegMEM(WriteRegMEM), .WriteRegWB(WriteRegWB),
        .MemReadMEM(MemReadMEM), .MemReadEX(MemReadEX), .WriteRegEX(WriteRegEX),
        .src_ex(src_ex), .src_id(src_id), .src_id_used(src_id_used),
        .fwd_sel(fwd_sel1), .ex_capture(ex_capture1),
        .stall_if(stall_if1), .stall_id(stall_id1), .flush_ex(flush_ex1),
        .freeze(freeze1), .stall_cnt(stall_cnt1)
    );

    typedef struct {
        logic       rwM, rwW;
        logic [4:0] wrM, wrW;
        logic       mrEx;
        logic [4:0] wrEx;
        logic [4:0] ex0, ex1, id0, id1;
        logic [1:0] used;
        logic [3:0] expFwd;
        logic       expLu;
    } vec_t;

    vec_t vecs[10];

    // behavioural model state: cycles the current load has spent in MEM,
    // per-channel captured flags and the stall count
    int   mHeld;
    int   mCnt;
    bit   mCapt[2];
    int   expSel[2];
    bit   expCap[2];
    int   rawSel[2];
    bit   frzExp, luExp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clearInputs();
        RegWriteMEM = 1'b0; RegWriteWB = 1'b0; MemReadMEM = 1'b0; MemReadEX = 1'b0;
        WriteRegMEM = '0; WriteRegWB = '0; WriteRegEX = '0;
        src_ex = '0; src_id = '0; src_id_used = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        clearInputs();
        @(negedge clk);
        reset = 1'b1;
        #1;
        reset = 1'b0;
        tick();
    endtask

    // drive MemReadMEM per cycle from mr (bit c) and expect freeze from exp (bit c)
    task automatic freezeSeq(input string name, input int n, input logic [15:0] mr,
                             input logic [15:0] exp);
        for (int c = 0; c < n; c++) begin
            MemReadMEM = mr[c];
            #1;
            check($sformatf("%s.freeze[%0d]", name, c), {31'b0, freeze}, {31'b0, exp[c]});
            check($sformatf("%s.stall_id[%0d]", name, c), {31'b0, stall_id}, {31'b0, exp[c]});
            tick();
        end
        MemReadMEM = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clearInputs();
        #2;
        check("reset.fwd_sel", {28'b0, fwd_sel}, 32'h0);
        check("reset.ex_capture", {30'b0, ex_capture}, 32'h0);
        check("reset.stall", {30'b0, stall_if, stall_id}, 32'h0);
        check("reset.flush_freeze", {30'b0, flush_ex, freeze}, 32'h0);
        check("reset.stall_cnt", {28'b0, stall_cnt}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        //                rwM   rwW   wrM   wrW   mrEx  wrEx  ex0   ex1   id0   id1   used   fwd      lu
        vecs[0] = '{1'b1, 1'b1, 5'd5, 5'd5, 1'b0, 5'd0, 5'd5, 5'd5, 5'd0, 5'd0, 2'b00, 4'b1010, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 5'd6, 5'd5, 1'b0, 5'd0, 5'd5, 5'd5, 5'd0, 5'd0, 2'b00, 4'b0101, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 2'b00, 4'b0000, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 4'b0000, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 5'd5, 5'd5, 1'b0, 5'd0, 5'd5, 5'd2, 5'd0, 5'd0, 2'b00, 4'b0001, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 5'd3, 5'd4, 1'b0, 5'd0, 5'd3, 5'd4, 5'd0, 5'd0, 2'b00, 4'b0110, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 2'b10, 4'b0000, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 2'b00, 4'b0000, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b01, 4'b0000, 1'b0};
        vecs[9] = '{1'b0, 1'b1, 5'd9, 5'd9, 1'b0, 5'd7, 5'd9, 5'd9, 5'd7, 5'd0, 2'b01, 4'b0101, 1'b0};

        for (int i = 0; i < 10; i++) begin
            RegWriteMEM = vecs[i].rwM;  RegWriteWB = vecs[i].rwW;
            WriteRegMEM = vecs[i].wrM;  WriteRegWB = vecs[i].wrW;
            MemReadEX   = vecs[i].mrEx; WriteRegEX = vecs[i].wrEx;
            src_ex      = {vecs[i].ex1, vecs[i].ex0};
            src_id      = {vecs[i].id1, vecs[i].id0};
            src_id_used = vecs[i].used;
            #1;
            check($sformatf("vec%0d.fwd_sel", i), {28'b0, fwd_sel}, {28'b0, vecs[i].expFwd});
            check($sformatf("vec%0d.stall_id", i), {31'b0, stall_id}, {31'b0, vecs[i].expLu});
            check($sformatf("vec%0d.flush_ex", i), {31'b0, flush_ex}, {31'b0, vecs[i].expLu});
            tick();
        end

        // load-use bubble and its count
        doReset();
        MemReadEX = 1'b1; WriteRegEX = 5'd7; src_id = {5'd7, 5'd0}; src_id_used = 2'b10;
        #1;
        check("lu.stall_if", {31'b0, stall_if}, 32'h1);
        check("lu.flush_ex", {31'b0, flush_ex}, 32'h1);
        check("lu.freeze", {31'b0, freeze}, 32'h0);
        tick();
        src_id_used = 2'b00;
        #1;
        check("lu.cnt", {28'b0, stall_cnt}, 32'h1);
        check("lu.unused_src", {31'b0, stall_id}, 32'h0);
        tick();
        check("lu.cnt_hold", {28'b0, stall_cnt}, 32'h1);

        // single load then back-to-back loads
        doReset();
        freezeSeq("load1", 4, 16'b0111, 16'b0011);
        check("load1.cnt", {28'b0, stall_cnt}, 32'h2);
        freezeSeq("load2", 7, 16'b0111111, 16'b0011011);
        check("load2.cnt", {28'b0, stall_cnt}, 32'h6);

        // WB-forwarded channel captured at freeze start; MEM-forwarded channel not
        doReset();
        MemReadMEM = 1'b1; RegWriteWB = 1'b1; WriteRegWB = 5'd4;
        RegWriteMEM = 1'b1; WriteRegMEM = 5'd9; src_ex = {5'd9, 5'd4};
        #1;
        check("cap.c0.ex_capture", {30'b0, ex_capture}, 32'h1);
        check("cap.c0.fwd_sel", {28'b0, fwd_sel}, 32'h9);
        tick();
        for (int c = 1; c < 3; c++) begin
            #1;
            check($sformatf("cap.c%0d.ex_capture", c), {30'b0, ex_capture}, 32'h0);
            check($sformatf("cap.c%0d.fwd_sel", c), {28'b0, fwd_sel}, 32'h8);
            tick();
        end
        MemReadMEM = 1'b0;
        #1;
        check("cap.c3.fwd_sel", {28'b0, fwd_sel}, 32'h9);
        check("cap.c3.freeze", {31'b0, freeze}, 32'h0);
        tick();

        // asynchronous reset while frozen
        doReset();
        MemReadMEM = 1'b1;
        #1;
        tick();
        MemReadMEM = 1'b0;
        #1;
        check("rstwait.frozen", {31'b0, freeze}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("rstwait.freeze", {31'b0, freeze}, 32'h0);
        check("rstwait.stall_id", {31'b0, stall_id}, 32'h0);
        check("rstwait.cnt", {28'b0, stall_cnt}, 32'h0);
        #1;
        reset = 1'b0;
        tick();
        freezeSeq("rstwait.reload", 4, 16'b0111, 16'b0011);
        check("rstwait.reload_cnt", {28'b0, stall_cnt}, 32'h2);

        // randomized traffic against the behavioural model
        doReset();
        mHeld = 0; mCnt = 0; mCapt[0] = 0; mCapt[1] = 0;
        for (int n = 0; n < 600; n++) begin
            RegWriteMEM = 1'($urandom_range(0, 1));
            RegWriteWB  = 1'($urandom_range(0, 1));
            WriteRegMEM = 5'($urandom_range(0, 7));
            WriteRegWB  = 5'($urandom_range(0, 7));
            MemReadMEM  = ($urandom_range(0, 5) == 0);
            MemReadEX   = ($urandom_range(0, 2) == 0);
            WriteRegEX  = 5'($urandom_range(0, 7));
            src_ex      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            src_id      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            src_id_used = 2'($urandom_range(0, 3));
            #1;

            if (mHeld == 0) frzExp = MemReadMEM && (LAT > 1);
            else            frzExp = (mHeld < int'(LAT) - 1);
            luExp = 1'b0;
            for (int ch = 0; ch < 2; ch++) begin
                int s, d;
                s = int'(src_ex[ch*5 +: 5]);
                d = int'(src_id[ch*5 +: 5]);
                if (RegWriteMEM && WriteRegMEM != 0 && int'(WriteRegMEM) == s)   rawSel[ch] = 2;
                else if (RegWriteWB && WriteRegWB != 0 && int'(WriteRegWB) == s) rawSel[ch] = 1;
                else                                                              rawSel[ch] = 0;
                expSel[ch] = mCapt[ch] ? 0 : rawSel[ch];
                expCap[ch] = (mHeld == 0) && frzExp && (expSel[ch] == 1);
                if (MemReadEX && WriteRegEX != 0 && src_id_used[ch] && d == int'(WriteRegEX))
                    luExp = 1'b1;
            end

            check("rnd.fwd_sel", {28'b0, fwd_sel}, 32'(expSel[1] * 4 + expSel[0]));
            check("rnd.ex_capture", {30'b0, ex_capture}, {30'b0, expCap[1], expCap[0]});
            check("rnd.freeze", {31'b0, freeze}, {31'b0, frzExp});
            check("rnd.stall", {30'b0, stall_if, stall_id}, {30'b0, frzExp || luExp, frzExp || luExp});
            check("rnd.flush_ex", {31'b0, flush_ex}, {31'b0, luExp && !frzExp});
            check("rnd.stall_cnt", {28'b0, stall_cnt}, 32'(mCnt));
            check("rnd1.fwd_sel", {28'b0, fwd_sel1}, 32'(rawSel[1] * 4 + rawSel[0]));
            check("rnd1.freeze_cap", {29'b0, freeze1, ex_capture1}, 32'h0);
            check("rnd1.stall_flush", {30'b0, stall_id1, flush_ex1}, {30'b0, luExp, luExp});

            tick();
            if ((frzExp || luExp) && mCnt < int'(CNT_MAX)) mCnt++;
            for (int ch = 0; ch < 2; ch++) mCapt[ch] = frzExp ? (mCapt[ch] || expCap[ch]) : 1'b0;
            mHeld = frzExp ? mHeld + 1 : 0;
        end
        check("rnd.saturated", {28'b0, stall_cnt}, 32'(CNT_MAX));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
